// File: rtl/fetch_stage.sv
// IF stage: PC register, word-addressed imem with combinational read, IF/ID register; instruction at PCF reaches InstrD one cycle later.
// StallF/StallD hold state, FlushD (or PCSF when FETCH_AUTOFLUSH_EN is defined) loads a NOP bubble into IF/ID.
module fetch_stage #(
    parameter int              XLEN       = 64,
    parameter int              IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PCSF,
    input  logic [XLEN-1:0]               PCTargetD,
    input  logic                          StallF,
    input  logic                          StallD,
    input  logic                          FlushD,
    input  logic                          ImemWrEn,
    input  logic [$clog2(IMEM_DEPTH)-1:0] ImemWrAddr,
    input  logic [31:0]                   ImemWrData,
    output logic [31:0]                   InstrD,
    output logic [XLEN-1:0]               PCD,
    output logic [XLEN-1:0]               PCPlus4D,
    output logic [XLEN-1:0]               PCF
);

    localparam int          AW  = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] target_aligned;
    logic [31:0]     imem_q [IMEM_DEPTH];
    logic [31:0]     instr_f;
    logic [31:0]     instr_d_q, instr_d_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcp4d_q, pcp4d_d;
    logic            flush_id;

    // Redirect wins over StallF; the target is forced word-aligned.
    always_comb begin
        pc_plus4_f     = pcf_q + XLEN'(4);
        target_aligned = PCTargetD & ~XLEN'(3);
        pcf_d          = pc_plus4_f;
        if (PCSF) begin
            pcf_d = target_aligned;
        end else if (StallF) begin
            pcf_d = pcf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcf_q <= RESET_PC;
        end else begin
            pcf_q <= pcf_d;
        end
    end

    // Memory is deliberately not reset so a program can be loaded while rst is high.
    always_ff @(posedge clk) begin
        if (ImemWrEn) begin
            imem_q[ImemWrAddr] <= ImemWrData;
        end
    end

    assign instr_f = imem_q[pcf_q[AW+1:2]];

    always_comb begin
`ifdef FETCH_AUTOFLUSH_EN
        flush_id = FlushD | PCSF;
`else
        flush_id = FlushD;
`endif
        instr_d_d = instr_d_q;
        pcd_d     = pcd_q;
        pcp4d_d   = pcp4d_q;
        if (flush_id) begin
            instr_d_d = NOP;
            pcd_d     = '0;
            pcp4d_d   = '0;
        end else if (!StallD) begin
            instr_d_d = instr_f;
            pcd_d     = pcf_q;
            pcp4d_d   = pc_plus4_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_d_q <= NOP;
            pcd_q     <= '0;
            pcp4d_q   <= '0;
        end else begin
            instr_d_q <= instr_d_d;
            pcd_q     <= pcd_d;
            pcp4d_q   <= pcp4d_d;
        end
    end

    assign InstrD   = instr_d_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4d_q;
    assign PCF      = pcf_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven cycle pushes the expected IF/ID and PC state, popped and compared after the edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h0050_0213;
    localparam logic [31:0] I1  = 32'h0031_7313;
    localparam logic [31:0] I2  = 32'h0031_0163;
    localparam logic [31:0] I3  = 32'h0000_0013;
    localparam logic [31:0] I8  = 32'h00A0_0093;
    localparam logic [31:0] I9  = 32'h0010_0113;
    localparam logic [31:0] IFF = 32'h0FF0_0093;
    localparam logic [31:0] NEW9 = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        rst;
        logic        pcsf;
        logic [63:0] tgt;
        logic        sf;
        logic        sd;
        logic        fd;
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
    } stim_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pcd;
        logic [63:0] p4;
        logic [63:0] pcf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        PCSF;
    logic [63:0] PCTargetD;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        ImemWrEn;
    logic [7:0]  ImemWrAddr;
    logic [31:0] ImemWrData;
    logic [31:0] InstrD;
    logic [63:0] PCD;
    logic [63:0] PCPlus4D;
    logic [63:0] PCF;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    fetch_stage #(.XLEN(64), .IMEM_DEPTH(256), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst), .PCSF(PCSF), .PCTargetD(PCTargetD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .ImemWrEn(ImemWrEn), .ImemWrAddr(ImemWrAddr), .ImemWrData(ImemWrData),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .PCF(PCF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic r, input logic pc, input logic [63:0] t,
                                 input logic sf, input logic sd, input logic fd,
                                 input logic we, input logic [7:0] wa, input logic [31:0] wd);
        stim_t s;
        s.rst = r; s.pcsf = pc; s.tgt = t; s.sf = sf; s.sd = sd; s.fd = fd;
        s.we = we; s.wa = wa; s.wd = wd;
        return s;
    endfunction

    function automatic exp_t mke(input logic [31:0] i, input logic [63:0] d,
                                 input logic [63:0] p4, input logic [63:0] f);
        exp_t e;
        e.instr = i; e.pcd = d; e.p4 = p4; e.pcf = f;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst; PCSF = s.pcsf; PCTargetD = s.tgt;
        StallF = s.sf; StallD = s.sd; FlushD = s.fd;
        ImemWrEn = s.we; ImemWrAddr = s.wa; ImemWrData = s.wd;
    endtask

    task automatic test_reset();
        stim_t st[9];
        exp_t  ex[9];
        exp_t  e;
        logic [7:0]  wa[7] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd8, 8'd9, 8'd255};
        logic [31:0] wd[7] = '{I0, I1, I2, I3, I8, I9, IFF};
        for (int k = 0; k < 7; k++) begin
            st[k] = mk(1, 0, 64'h0, 0, 0, 0, 1, wa[k], wd[k]);
            ex[k] = mke(NOP, 64'h0, 64'h0, 64'h0);
        end
        st[7] = mk(0, 0, 64'h0, 0, 0, 0, 0, 8'd0, 32'h0); ex[7] = mke(I0, 64'h0, 64'h4, 64'h4);
        st[8] = st[7];                                     ex[8] = mke(I1, 64'h4, 64'h8, 64'h8);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); drive(st[i]); exp_q.push_back(ex[i]);
            @(posedge clk); #1; e = exp_q.pop_front();
            checks += 4;
            if (InstrD !== e.instr) begin errors++; $display("FAIL reset[%0d] InstrD got %h want %h", i, InstrD, e.instr); end
            if (PCD !== e.pcd) begin errors++; $display("FAIL reset[%0d] PCD got %h want %h", i, PCD, e.pcd); end
            if (PCPlus4D !== e.p4) begin errors++; $display("FAIL reset[%0d] PCPlus4D got %h want %h", i, PCPlus4D, e.p4); end
            if (PCF !== e.pcf) begin errors++; $display("FAIL reset[%0d] PCF got %h want %h", i, PCF, e.pcf); end
        end
    endtask

    task automatic test_stall();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e;
        st[0] = mk(0, 0, 64'h0, 1, 1, 0, 0, 8'd0, 32'h0); ex[0] = mke(I1, 64'h4, 64'h8, 64'h8);
        st[1] = st[0];                                     ex[1] = ex[0];
        st[2] = mk(0, 0, 64'h0, 0, 0, 0, 0, 8'd0, 32'h0); ex[2] = mke(I2, 64'h8, 64'hC, 64'hC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(st[i]); exp_q.push_back(ex[i]);
            @(posedge clk); #1; e = exp_q.pop_front();
            checks += 4;
            if (InstrD !== e.instr) begin errors++; $display("FAIL stall[%0d] InstrD got %h want %h", i, InstrD, e.instr); end
            if (PCD !== e.pcd) begin errors++; $display("FAIL stall[%0d] PCD got %h want %h", i, PCD, e.pcd); end
            if (PCPlus4D !== e.p4) begin errors++; $display("FAIL stall[%0d] PCPlus4D got %h want %h", i, PCPlus4D, e.p4); end
            if (PCF !== e.pcf) begin errors++; $display("FAIL stall[%0d] PCF got %h want %h", i, PCF, e.pcf); end
        end
    endtask

    task automatic test_redirect();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e;
        st[0] = mk(0, 1, 64'h22, 0, 0, 1, 0, 8'd0, 32'h0); ex[0] = mke(NOP, 64'h0, 64'h0, 64'h20);
        st[1] = mk(0, 0, 64'h0, 0, 0, 0, 0, 8'd0, 32'h0);  ex[1] = mke(I8, 64'h20, 64'h24, 64'h24);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(st[i]); exp_q.push_back(ex[i]);
            @(posedge clk); #1; e = exp_q.pop_front();
            checks += 4;
            if (InstrD !== e.instr) begin errors++; $display("FAIL redirect[%0d] InstrD got %h want %h", i, InstrD, e.instr); end
            if (PCD !== e.pcd) begin errors++; $display("FAIL redirect[%0d] PCD got %h want %h", i, PCD, e.pcd); end
            if (PCPlus4D !== e.p4) begin errors++; $display("FAIL redirect[%0d] PCPlus4D got %h want %h", i, PCPlus4D, e.p4); end
            if (PCF !== e.pcf) begin errors++; $display("FAIL redirect[%0d] PCF got %h want %h", i, PCF, e.pcf); end
        end
    endtask

    task automatic test_priority();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e;
        st[0] = mk(0, 1, 64'hC, 1, 1, 1, 0, 8'd0, 32'h0); ex[0] = mke(NOP, 64'h0, 64'h0, 64'hC);
        st[1] = mk(0, 0, 64'h0, 1, 1, 0, 0, 8'd0, 32'h0); ex[1] = mke(NOP, 64'h0, 64'h0, 64'hC);
        st[2] = mk(0, 0, 64'h0, 0, 0, 0, 0, 8'd0, 32'h0); ex[2] = mke(I3, 64'hC, 64'h10, 64'h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(st[i]); exp_q.push_back(ex[i]);
            @(posedge clk); #1; e = exp_q.pop_front();
            checks += 4;
            if (InstrD !== e.instr) begin errors++; $display("FAIL priority[%0d] InstrD got %h want %h", i, InstrD, e.instr); end
            if (PCD !== e.pcd) begin errors++; $display("FAIL priority[%0d] PCD got %h want %h", i, PCD, e.pcd); end
            if (PCPlus4D !== e.p4) begin errors++; $display("FAIL priority[%0d] PCPlus4D got %h want %h", i, PCPlus4D, e.p4); end
            if (PCF !== e.pcf) begin errors++; $display("FAIL priority[%0d] PCF got %h want %h", i, PCF, e.pcf); end
        end
    endtask

    task automatic test_wrap();
        stim_t st[5];
        exp_t  ex[5];
        exp_t  e;
        stim_t run = mk(0, 0, 64'h0, 0, 0, 0, 0, 8'd0, 32'h0);
        st[0] = mk(0, 1, 64'h400, 0, 0, 1, 0, 8'd0, 32'h0);
        ex[0] = mke(NOP, 64'h0, 64'h0, 64'h400);
        st[1] = run; ex[1] = mke(I0, 64'h400, 64'h404, 64'h404);
        st[2] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 0, 8'd0, 32'h0);
        ex[2] = mke(NOP, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
        st[3] = run; ex[3] = mke(IFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0);
        st[4] = run; ex[4] = mke(I0, 64'h0, 64'h4, 64'h4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(st[i]); exp_q.push_back(ex[i]);
            @(posedge clk); #1; e = exp_q.pop_front();
            checks += 4;
            if (InstrD !== e.instr) begin errors++; $display("FAIL wrap[%0d] InstrD got %h want %h", i, InstrD, e.instr); end
            if (PCD !== e.pcd) begin errors++; $display("FAIL wrap[%0d] PCD got %h want %h", i, PCD, e.pcd); end
            if (PCPlus4D !== e.p4) begin errors++; $display("FAIL wrap[%0d] PCPlus4D got %h want %h", i, PCPlus4D, e.p4); end
            if (PCF !== e.pcf) begin errors++; $display("FAIL wrap[%0d] PCF got %h want %h", i, PCF, e.pcf); end
        end
    endtask

    task automatic test_autoflush();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e;
        st[0] = mk(0, 1, 64'h20, 0, 0, 0, 0, 8'd0, 32'h0);
`ifdef FETCH_AUTOFLUSH_EN
        ex[0] = mke(NOP, 64'h0, 64'h0, 64'h20);
`else
        ex[0] = mke(I1, 64'h4, 64'h8, 64'h20);
`endif
        st[1] = mk(0, 0, 64'h0, 0, 0, 0, 0, 8'd0, 32'h0);
        ex[1] = mke(I8, 64'h20, 64'h24, 64'h24);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(st[i]); exp_q.push_back(ex[i]);
            @(posedge clk); #1; e = exp_q.pop_front();
            checks += 4;
            if (InstrD !== e.instr) begin errors++; $display("FAIL autoflush[%0d] InstrD got %h want %h", i, InstrD, e.instr); end
            if (PCD !== e.pcd) begin errors++; $display("FAIL autoflush[%0d] PCD got %h want %h", i, PCD, e.pcd); end
            if (PCPlus4D !== e.p4) begin errors++; $display("FAIL autoflush[%0d] PCPlus4D got %h want %h", i, PCPlus4D, e.p4); end
            if (PCF !== e.pcf) begin errors++; $display("FAIL autoflush[%0d] PCF got %h want %h", i, PCF, e.pcf); end
        end
    endtask

    // Write to the word being fetched: the IF/ID register must capture the old word.
    task automatic test_back_to_back();
        stim_t st[3];
        exp_t  ex[3];
        exp_t  e;
        st[0] = mk(0, 0, 64'h0, 0, 0, 0, 1, 8'd9, NEW9);  ex[0] = mke(I9, 64'h24, 64'h28, 64'h28);
        st[1] = mk(0, 1, 64'h24, 0, 0, 1, 0, 8'd0, 32'h0); ex[1] = mke(NOP, 64'h0, 64'h0, 64'h24);
        st[2] = mk(0, 0, 64'h0, 0, 0, 0, 0, 8'd0, 32'h0);  ex[2] = mke(NEW9, 64'h24, 64'h28, 64'h28);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(st[i]); exp_q.push_back(ex[i]);
            @(posedge clk); #1; e = exp_q.pop_front();
            checks += 4;
            if (InstrD !== e.instr) begin errors++; $display("FAIL imemrw[%0d] InstrD got %h want %h", i, InstrD, e.instr); end
            if (PCD !== e.pcd) begin errors++; $display("FAIL imemrw[%0d] PCD got %h want %h", i, PCD, e.pcd); end
            if (PCPlus4D !== e.p4) begin errors++; $display("FAIL imemrw[%0d] PCPlus4D got %h want %h", i, PCPlus4D, e.p4); end
            if (PCF !== e.pcf) begin errors++; $display("FAIL imemrw[%0d] PCF got %h want %h", i, PCF, e.pcf); end
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[2];
        exp_t  ex[2];
        exp_t  e;
        st[0] = mk(1, 1, 64'h100, 1, 1, 0, 0, 8'd0, 32'h0); ex[0] = mke(NOP, 64'h0, 64'h0, 64'h0);
        st[1] = mk(0, 0, 64'h0, 0, 0, 0, 0, 8'd0, 32'h0);   ex[1] = mke(I0, 64'h0, 64'h4, 64'h4);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(st[i]); exp_q.push_back(ex[i]);
            @(posedge clk); #1; e = exp_q.pop_front();
            checks += 4;
            if (InstrD !== e.instr) begin errors++; $display("FAIL rstmid[%0d] InstrD got %h want %h", i, InstrD, e.instr); end
            if (PCD !== e.pcd) begin errors++; $display("FAIL rstmid[%0d] PCD got %h want %h", i, PCD, e.pcd); end
            if (PCPlus4D !== e.p4) begin errors++; $display("FAIL rstmid[%0d] PCPlus4D got %h want %h", i, PCPlus4D, e.p4); end
            if (PCF !== e.pcf) begin errors++; $display("FAIL rstmid[%0d] PCF got %h want %h", i, PCF, e.pcf); end
        end
    endtask

    initial begin
        drive(mk(1, 0, 64'h0, 0, 0, 0, 0, 8'd0, 32'h0));
        test_reset();
        test_stall();
        test_redirect();
        test_priority();
        test_wrap();
        test_autoflush();
        test_back_to_back();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover entries %0d want 0", exp_q.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 64-bit five-stage RISC-V pipeline, directly upstream of decode_stage.
- Owns the PC register, a word-addressed instruction memory, PC+4 generation and the IF/ID pipeline register.
- Drives InstrD, PCD and PCPlus4D into decode.
- Consumes the branch/jump redirect (PCSF, PCTargetD) from decode, and StallF/StallD/FlushD from the hazard unit.

Parameters:
- XLEN, 64, datapath and PC width.
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words; power of two, at least 4.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- PCSF  input  1  redirect select from decode: 1 means next PC = PCTargetD.
- PCTargetD  input  XLEN  redirect target from decode.
- StallF  input  1  hold PC register.
- StallD  input  1  hold IF/ID register.
- FlushD  input  1  load bubble into IF/ID register.
- ImemWrEn  input  1  instruction memory write enable (program load).
- ImemWrAddr  input  $clog2(IMEM_DEPTH)  word index to write.
- ImemWrData  input  32  instruction word to write.
- InstrD  output  32  instruction to decode.
- PCD  output  XLEN  PC of InstrD.
- PCPlus4D  output  XLEN  PCD+4.
- PCF  output  XLEN  current fetch PC, for debug and hazard unit.

Behaviour:
- Reset, synchronous active-high:
  - PCF = RESET_PC.
  - InstrD = 32'h00000013 (NOP, addi x0,x0,0).
  - PCD = 0, PCPlus4D = 0.
  - Memory contents are not cleared.
- PC register priority, highest first:
  - rst.
  - PCSF: PCF <= {PCTargetD[XLEN-1:2], 2'b00}. Redirect overrides StallF.
  - StallF: PCF holds.
  - Otherwise: PCF <= PCF+4.
- PCPlusF = PCF+4, modulo 2^XLEN. 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0 without error.
- Instruction read:
  - Combinational read of imem[PCF[$clog2(IMEM_DEPTH)+1:2]].
  - Upper PC bits are ignored, so the address wraps modulo IMEM_DEPTH words.
- IF/ID register priority, highest first:
  - rst.
  - FlushD: InstrD = NOP, PCD = 0, PCPlus4D = 0. FlushD overrides StallD.
  - StallD: all three outputs hold.
  - Otherwise: InstrD <= imem read, PCD <= PCF, PCPlus4D <= PCPlusF.
- Latency: the instruction at PCF appears on InstrD/PCD one cycle later.
- Redirect timing:
  - PCSF is asserted while the branch is in decode, so the wrong-path instruction fetched that cycle enters IF/ID on the same edge.
  - The hazard unit is responsible for asserting FlushD in that cycle. This block does not self-flush unless FETCH_AUTOFLUSH_EN is defined.
- Imem write:
  - Synchronous, on the rising edge when ImemWrEn=1.
  - A same-cycle read of the same address returns the old word.
  - Writes are accepted during rst.
- StallF=1 with StallD=0 is legal: the same instruction is registered again (duplicate). The hazard unit avoids this combination.
- Reset asserted mid-stall or mid-redirect: reset wins; the next cycle fetches from RESET_PC.
- Out-of-range imem contents: the memory is uninitialised (X) until written. No initial-file loading.

Optional Feature:
- Macro FETCH_AUTOFLUSH_EN.
- Defined: IF/ID flush condition becomes (FlushD | PCSF), so a taken redirect inserts a NOP into IF/ID without hazard-unit help. StallD is still overridden.
- Undefined: only FlushD flushes, exactly as in Behaviour.
- PC behaviour is identical in both builds.

Test Plan:
- Reset fetch:
  - Stimulus: load imem[0..3] = 0x00500213, 0x00317313, 0x00310163, 0x00000013; rst=1 for 2 cycles, then release.
  - Required response: during reset InstrD=0x00000013 and PCD=0. On successive cycles PCD=0/4/8, with InstrD=0x00500213/0x00317313/0x00310163 and PCPlus4D=4/8/0xC.
- Stall:
  - Stimulus: StallF=StallD=1 for 2 cycles while PCF=8.
  - Required response: PCF stays 8; InstrD/PCD hold 0x00317313/4. After release PCD=8.
- Redirect:
  - Stimulus: PCSF=1 and PCTargetD=0x22 for one cycle with PCF=0xC, FlushD=1 in the same cycle.
  - Required response: next PCF=0x20; InstrD=NOP with PCD=0; the cycle after, PCD=0x20.
- Priority:
  - Stimulus: FlushD=1 with StallD=1; PCSF=1 with StallF=1.
  - Required response: IF/ID holds NOP; PCF loads PCTargetD.
- Wrap:
  - Stimulus: IMEM_DEPTH=256, PCF=0x400.
  - Required response: reads imem[0]. PCTargetD=64'hFFFF_FFFF_FFFF_FFFC then free-run gives PCF wrapping to 0.
- Autoflush (build with FETCH_AUTOFLUSH_EN):
  - Stimulus: PCSF=1 with FlushD=0.
  - Required response: InstrD=NOP on the next cycle.
  - Without the macro, the same stimulus registers the wrong-path word.
